// File: rtl/payload_capture_fifo.sv
// Byte FIFO behind the sync-pattern comparator: captures DBUS while WREN is high,
// reports each burst's accepted length, and drains through a one-cycle read handshake.
module payload_capture_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    DBUS,
  input  logic          WREN,
  input  logic          RD_EN,
  output logic [7:0]    RD_DATA,
  output logic          RD_VALID,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          FRAME_RDY,
  output logic [AW:0]   BURST_LEN,
  output logic          OVERFLOW
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, BURST} state_e;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          ovf_q, ovf_d;
  state_e        state_q, state_d;
  logic [AW:0]   bcnt_q, bcnt_d;
  logic          frame_q, frame_d;
  logic [AW:0]   blen_q, blen_d;
  logic          rd_ok, wr_ok;

  // Read is decided on the pre-write occupancy, so an empty FIFO never bypasses.
  assign rd_ok = RD_EN && (cnt_q != '0);
  assign wr_ok = WREN && ((cnt_q != DEPTH_C) || rd_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (WREN && !wr_ok) ovf_d = 1'b1;
    if (rd_ok) begin
      rd_data_d  = mem[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + AW'(1);
      rd_valid_d = 1'b1;
    end
    if (wr_ok && !rd_ok) cnt_d = cnt_q + (AW+1)'(1);
    else if (rd_ok && !wr_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    frame_d = 1'b0;
    blen_d  = blen_q;
    case (state_q)
      IDLE: if (WREN) begin
        state_d = BURST;
        bcnt_d  = wr_ok ? (AW+1)'(1) : '0;
      end
      BURST: if (WREN) begin
        if (wr_ok && bcnt_q != DEPTH_C) bcnt_d = bcnt_q + (AW+1)'(1);
      end else begin
        state_d = IDLE;
        frame_d = 1'b1;
        blen_d  = bcnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_ok && !RST) mem[wr_ptr_q] <= DBUS;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      bcnt_q     <= '0;
      frame_q    <= 1'b0;
      blen_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      frame_q    <= frame_d;
      blen_q     <= blen_d;
    end
  end

  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign COUNT     = cnt_q;
  assign EMPTY     = (cnt_q == '0);
  assign FULL      = (cnt_q == DEPTH_C);
  assign FRAME_RDY = frame_q;
  assign BURST_LEN = blen_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_payload_capture_fifo.sv
// Directed bench for payload_capture_fifo; a queue-based reference tracks bytes,
// read results and burst lengths, and every cycle is compared against it.
module tb_payload_capture_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    DBUS = '0;
  logic          WREN = 1'b0;
  logic          RD_EN = 1'b0;
  logic [7:0]    RD_DATA;
  logic          RD_VALID, EMPTY, FULL, FRAME_RDY, OVERFLOW;
  logic [AW:0]   COUNT, BURST_LEN;

  payload_capture_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .DBUS(DBUS), .WREN(WREN), .RD_EN(RD_EN),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .EMPTY(EMPTY), .FULL(FULL),
    .COUNT(COUNT), .FRAME_RDY(FRAME_RDY), .BURST_LEN(BURST_LEN), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [7:0] mq[$];
  logic [7:0] exp_rd[$];
  logic [7:0] m_rd_data = 8'h00;
  logic       m_rd_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_in_burst = 1'b0;
  int         m_bcnt = 0;
  logic       m_frame = 1'b0;
  int         m_len = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 16'(COUNT), 16'(mq.size()));
    chk({tag, ".empty"}, 16'(EMPTY), 16'(mq.size() == 0));
    chk({tag, ".full"}, 16'(FULL), 16'(mq.size() == DEPTH));
    chk({tag, ".rd_valid"}, 16'(RD_VALID), 16'(m_rd_valid));
    chk({tag, ".rd_data"}, 16'(RD_DATA), 16'(m_rd_data));
    chk({tag, ".overflow"}, 16'(OVERFLOW), 16'(m_ovf));
    chk({tag, ".frame_rdy"}, 16'(FRAME_RDY), 16'(m_frame));
    chk({tag, ".burst_len"}, 16'(BURST_LEN), 16'(m_len));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_rd.delete();
    m_rd_data = 8'h00; m_rd_valid = 1'b0; m_ovf = 1'b0;
    m_in_burst = 1'b0; m_bcnt = 0; m_frame = 1'b0; m_len = 0;
  endtask

  // One clock: drive inputs, advance the reference, compare #1 after the edge.
  task automatic cyc(input string tag, input logic w, input logic [7:0] d, input logic r);
    logic rok, wok;
    WREN = w; DBUS = d; RD_EN = r;
    rok = r && (mq.size() > 0);
    wok = w && ((mq.size() < DEPTH) || rok);
    m_rd_valid = rok;
    if (rok) exp_rd.push_back(mq.pop_front());
    if (wok) mq.push_back(d);
    if (w && !wok) m_ovf = 1'b1;
    m_frame = 1'b0;
    if (m_in_burst && !w) begin
      m_frame = 1'b1; m_len = m_bcnt; m_in_burst = 1'b0;
    end else if (!m_in_burst && w) begin
      m_in_burst = 1'b1; m_bcnt = wok ? 1 : 0;
    end else if (m_in_burst && w && wok && m_bcnt < DEPTH) begin
      m_bcnt++;
    end
    @(posedge CLK); #1;
    if (rok) m_rd_data = exp_rd.pop_front();
    check_all(tag);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    RST = 1'b0;
    cyc("idle", 1'b0, 8'h00, 1'b0);

    // single frame
    cyc("sf_w", 1'b1, 8'h11, 1'b0);
    cyc("sf_w", 1'b1, 8'h22, 1'b0);
    cyc("sf_w", 1'b1, 8'h33, 1'b0);
    cyc("sf_w", 1'b1, 8'h44, 1'b0);
    cyc("sf_end", 1'b0, 8'h00, 1'b0);
    chk("sf_frame", 16'(FRAME_RDY), 16'd1);
    chk("sf_len", 16'(BURST_LEN), 16'd4);
    chk("sf_count", 16'(COUNT), 16'd4);
    cyc("sf_gap", 1'b0, 8'h00, 1'b0);
    chk("sf_pulse_once", 16'(FRAME_RDY), 16'd0);
    chk("sf_len_hold", 16'(BURST_LEN), 16'd4);
    cyc("sf_r", 1'b0, 8'h00, 1'b1);
    chk("sf_rd0", 16'(RD_DATA), 16'h11);
    cyc("sf_r", 1'b0, 8'h00, 1'b1);
    chk("sf_rd1", 16'(RD_DATA), 16'h22);
    cyc("sf_r", 1'b0, 8'h00, 1'b1);
    cyc("sf_r", 1'b0, 8'h00, 1'b1);
    chk("sf_rd3", 16'(RD_DATA), 16'h44);
    chk("sf_empty", 16'(EMPTY), 16'd1);
    cyc("sf_hold", 1'b0, 8'h00, 1'b0);
    chk("sf_rdata_hold", 16'(RD_DATA), 16'h44);

    // read while empty is ignored even with a same-cycle write
    cyc("er", 1'b1, 8'hA5, 1'b1);
    chk("er_valid", 16'(RD_VALID), 16'd0);
    chk("er_count", 16'(COUNT), 16'd1);
    cyc("er_rd", 1'b0, 8'h00, 1'b1);
    chk("er_data", 16'(RD_DATA), 16'hA5);
    cyc("er_gap", 1'b0, 8'h00, 1'b0);

    // wrap-around
    for (int i = 0; i < 12; i++) cyc("wr12", 1'b1, 8'(8'hC0 + i), 1'b0);
    cyc("wr12_end", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cyc("rd12", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) cyc("wr8", 1'b1, 8'(i + 1), 1'b0);
    cyc("wr8_end", 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc("rd8", 1'b0, 8'h00, 1'b1);
      chk("wrap_data", 16'(RD_DATA), 16'(i + 1));
    end

    // simultaneous read/write while full
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 8'(8'h60 + i), 1'b0);
    chk("fill_full", 16'(FULL), 16'd1);
    for (int i = 0; i < 3; i++) begin
      cyc("rw_full", 1'b1, 8'(8'h90 + i), 1'b1);
      chk("rw_count", 16'(COUNT), 16'd16);
      chk("rw_data", 16'(RD_DATA), 16'(8'h60 + i));
      chk("rw_ovf", 16'(OVERFLOW), 16'd0);
    end
    cyc("rw_end", 1'b0, 8'h00, 1'b0);
    chk("rw_len_sat", 16'(BURST_LEN), 16'd16);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 8'h00, 1'b1);
    cyc("drain_extra", 1'b0, 8'h00, 1'b1);

    // overflow
    for (int i = 0; i < 18; i++) cyc("ovf_w", 1'b1, 8'(8'h20 + i), 1'b0);
    chk("ovf_full", 16'(FULL), 16'd1);
    chk("ovf_flag", 16'(OVERFLOW), 16'd1);
    cyc("ovf_end", 1'b0, 8'h00, 1'b0);
    chk("ovf_frame", 16'(FRAME_RDY), 16'd1);
    chk("ovf_len", 16'(BURST_LEN), 16'd16);
    for (int i = 0; i < DEPTH; i++) cyc("ovf_r", 1'b0, 8'h00, 1'b1);
    chk("ovf_last_kept", 16'(RD_DATA), 16'h2F);
    chk("ovf_sticky", 16'(OVERFLOW), 16'd1);

    // reset mid-burst with 5 bytes stored and a read in flight
    for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, 8'(8'h70 + i), 1'b0);
    cyc("pre_rst_rd", 1'b1, 8'h75, 1'b1);
    chk("pre_rst_valid", 16'(RD_VALID), 16'd1);
    WREN = 1'b0; RD_EN = 1'b0;
    RST = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    repeat (2) begin
      @(posedge CLK); #1;
      check_all("rst_hold");
    end
    RST = 1'b0;
    cyc("post_rst", 1'b0, 8'h00, 1'b0);
    cyc("post_rst", 1'b0, 8'h00, 1'b0);
    cyc("post_w", 1'b1, 8'h5A, 1'b0);
    cyc("post_end", 1'b0, 8'h00, 1'b0);
    chk("post_len", 16'(BURST_LEN), 16'd1);
    cyc("post_rd", 1'b0, 8'h00, 1'b1);
    chk("post_data", 16'(RD_DATA), 16'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
